blur_mm_master: RTL and testbench

Avalon-MM initiator that drives the 3x3 Gaussian convolution register slave. It accepts one 3x3 pixel window per valid/ready handshake and writes the nine pixels to slave registers 0–8. It then reads the filtered result from register 9 and returns it on a valid/ready output. It sits between the image line-buffer/window generator and the convolution slave, replacing CPU-driven register pokes with a hardware sequencer.

---
 rtl/blur_mm_master.sv | 127 ++++++++++++
 tb/tb_blur_mm_master.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/blur_mm_master.sv
// Avalon-MM initiator that feeds one 3x3 window to the Gaussian conv slave
// (registers 0..8), reads the result from register 9 and returns it on a handshake.
module blur_mm_master #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [71:0] in_window,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_pixel,
  output logic        err,
  output logic [3:0]  m_addr,
  output logic [31:0] m_wdata,
  output logic        m_cs,
  output logic        m_write,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [31:0] m_rdata
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, OUT} state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t          state_q;
  logic [8:0][7:0] win_q;
  logic [3:0]      idx_q;
  logic [2:0]      lat_q;
  logic            out_valid_q;
  logic [7:0]      out_pixel_q;
  logic            err_q;
  logic [3:0]      m_addr_q;
  logic [31:0]     m_wdata_q;
  logic            m_cs_q;
  logic            m_write_q;
  logic            m_read_q;
  logic [3:0]      idx_d;

  assign idx_d = idx_q + 4'd1;

  // Bus outputs are registered and loaded one state ahead, so they are valid
  // in the first cycle of WRITE/READ and frozen whenever waitrequest stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      err_q       <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_cs_q      <= 1'b0;
      m_write_q   <= 1'b0;
      m_read_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            win_q     <= in_window;
            idx_q     <= '0;
            m_cs_q    <= 1'b1;
            m_write_q <= 1'b1;
            m_addr_q  <= '0;
            m_wdata_q <= {24'd0, in_window[7:0]};
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          if (!m_waitrequest) begin
            if (idx_q == 4'd8) begin
              m_write_q <= 1'b0;
              m_read_q  <= 1'b1;
              m_addr_q  <= 4'd9;
              m_wdata_q <= '0;
              state_q   <= READ;
            end else begin
              idx_q     <= idx_d;
              m_addr_q  <= idx_d;
              m_wdata_q <= {24'd0, win_q[idx_d]};
            end
          end
        end
        READ: begin
          if (!m_waitrequest) begin
            m_cs_q   <= 1'b0;
            m_read_q <= 1'b0;
            m_addr_q <= '0;
            lat_q    <= LAT;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          lat_q <= lat_q - 3'd1;
          if (lat_q == 3'd1) begin
            out_pixel_q <= m_rdata[7:0];
            out_valid_q <= 1'b1;
            if (m_rdata[31:8] != 24'd0) err_q <= 1'b1;
            state_q <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign err       = err_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_cs      = m_cs_q;
  assign m_write   = m_write_q;
  assign m_read    = m_read_q;

endmodule

// File: tb/tb_blur_mm_master.sv
// Bench for blur_mm_master: behavioural conv-slave model, Gaussian reference,
// directed and randomized windows with waitrequest stalls, reset abort and err.
module tb_blur_mm_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [71:0] in_window = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_pixel;
  logic        err;
  logic [3:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_cs;
  logic        m_write;
  logic        m_read;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_rdata = '0;

  int passed = 0;
  int total  = 0;

  // stall configuration (written by the stimulus only)
  int unsigned st_addr = 0;
  int unsigned st_wn   = 0;
  int unsigned st_rn   = 0;
  logic        rd_ovr  = 1'b0;

  blur_mm_master #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_window(in_window),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .err(err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_cs(m_cs), .m_write(m_write),
    .m_read(m_read), .m_waitrequest(m_waitrequest), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gauss(input logic [71:0] w);
    int wt [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    int sum = 0;
    for (int k = 0; k < 9; k++) sum += wt[k] * int'(w[8*k +: 8]);
    return 8'(sum >> 4);
  endfunction

  // Conv slave model with read latency 1; registers survive master reset.
  logic [71:0] sregs = '0;
  logic [35:0] wlog [0:15];
  int          wlen = 0;
  int          rdn  = 0;
  always @(posedge clk) begin
    if (m_cs && !m_waitrequest) begin
      if (m_write) begin
        if (m_addr < 4'd9) sregs[8*int'(m_addr) +: 8] <= m_wdata[7:0];
        if (wlen < 16) wlog[wlen] <= {m_addr, m_wdata};
        wlen <= wlen + 1;
      end
      if (m_read) begin
        m_rdata <= rd_ovr ? 32'h0000_0100 : {24'd0, gauss(sregs)};
        rdn     <= rdn + 1;
      end
    end
    if (in_valid && in_ready) begin
      wlen <= 0;
      rdn  <= 0;
    end
  end

  // Waitrequest generator: directed stalls during the bus phase, random noise outside it.
  int unsigned wcnt = 0;
  int unsigned rcnt = 0;
  always @(negedge clk) begin
    if (!m_cs) begin
      wcnt          <= 0;
      rcnt          <= 0;
      m_waitrequest <= 1'($urandom_range(0, 1));
    end else if (m_write && int'(m_addr) == st_addr && wcnt < st_wn) begin
      wcnt          <= wcnt + 1;
      m_waitrequest <= 1'b1;
    end else if (m_read && rcnt < st_rn) begin
      rcnt          <= rcnt + 1;
      m_waitrequest <= 1'b1;
    end else begin
      m_waitrequest <= 1'b0;
    end
  end

  // Outputs must not move across a stalled edge.
  logic        prev_stall = 1'b0;
  logic [38:0] prev_bus   = '0;
  int          stab_bad   = 0;
  always @(posedge clk) begin
    if (prev_stall && !rst && prev_bus !== {m_cs, m_write, m_read, m_addr, m_wdata})
      stab_bad <= stab_bad + 1;
    prev_stall <= m_cs && m_waitrequest && !rst;
    prev_bus   <= {m_cs, m_write, m_read, m_addr, m_wdata};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input logic [71:0] w, input int unsigned wa, input int unsigned wn,
                     input int unsigned rn, input int unsigned hold, input logic ovr,
                     input logic exp_err);
    int          n;
    int          bad;
    logic [71:0] junk;
    logic [7:0]  exp_pix;
    exp_pix = ovr ? 8'h00 : gauss(w);
    st_addr = wa; st_wn = wn; st_rn = rn; rd_ovr = ovr;
    @(negedge clk);
    in_window = w;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    junk      = {8'($urandom()), $urandom(), $urandom()};
    in_window = junk;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 200);
    check("latency", 32'(n - 1), 32'(11 + wn + rn));
    check("out_pixel", 32'(out_pixel), 32'(exp_pix));
    check("err", 32'(err), 32'(exp_err));
    if (hold > 0) begin
      bad = 0;
      for (int i = 0; i < int'(hold); i++) begin
        @(negedge clk);
        if (out_valid !== 1'b1 || out_pixel !== exp_pix || in_ready !== 1'b0 ||
            m_cs !== 1'b0 || m_write !== 1'b0 || m_read !== 1'b0) bad++;
      end
      check("hold_stable", 32'(bad), 32'd0);
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid_after_hs", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
    check("write_count", 32'(wlen), 32'd9);
    bad = 0;
    for (int k = 0; k < 9; k++)
      if (wlog[k] !== {4'(k), 24'd0, w[8*k +: 8]}) bad++;
    check("write_beats", 32'(bad), 32'd0);
    check("read_count", 32'(rdn), 32'd1);
    check("stall_stable", 32'(stab_bad), 32'd0);
  endtask

  initial begin
    logic [71:0] w;
    int          n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pixel", 32'(out_pixel), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_strobes", {29'd0, m_cs, m_write, m_read}, 32'd0);
    check("rst_addr_data", {m_addr, m_wdata[27:0]}, 32'd0);
    check("rst_wdata_hi", {28'd0, m_wdata[31:28]}, 32'd0);
    rst = 1'b0;

    run({9{8'h80}}, 0, 0, 0, 0, 1'b0, 1'b0);
    run({32'd0, 8'hFF, 32'd0}, 0, 0, 0, 0, 1'b0, 1'b0);
    run({9{8'hFF}}, 0, 0, 0, 0, 1'b0, 1'b0);
    run({8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 0, 0, 0, 0, 1'b0, 1'b0);
    run({8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 4, 3, 2, 0, 1'b0, 1'b0);
    run({9{8'h80}}, 0, 0, 0, 10, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      w = {8'($urandom()), $urandom(), $urandom()};
      run(w, $urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1) * 3, 1'b0, 1'b0);
    end

    // reset during the write of address 5
    st_wn = 0; st_rn = 0;
    @(negedge clk);
    in_window = {9{8'h33}};
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(m_write && m_addr == 4'd5) && n < 50);
    check("reached_addr5", 32'(m_addr), 32'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_strobes", {29'd0, m_cs, m_write, m_read}, 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    run({8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90}, 0, 0, 0, 0, 1'b0, 1'b0);

    // nonzero upper read data sets a sticky err
    run({9{8'h55}}, 0, 0, 0, 0, 1'b1, 1'b1);
    run({9{8'h44}}, 2, 1, 1, 0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("err_cleared_by_rst", 32'(err), 32'd0);
    rst = 1'b0;
    run({9{8'h22}}, 0, 0, 0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
